mux_tree_pipe: RTL and testbench

Parametrised, pipelined N:1 multiplexer built as a binary tree of 2:1 levels. It generalises the fixed 1-bit 4:1 mux to WIDTH-bit data and N_IN channels, with optional per-level pipeline registers. It carries a valid strobe and channel tag alongside the data, and adds an auto-scan mode that walks the channels round-robin. It sits between parallel data sources and a single serial consumer, for example a channel serialiser ahead of a UART or debug port.

---
 rtl/mux_tree_pipe_pkg.sv | 21 ++
 rtl/mux_tree_pipe_if.sv | 27 ++
 rtl/mux_tree_pipe_mux2_stage.sv | 47 ++++
 rtl/mux_tree_pipe.sv | 94 +++++++++
 tb/tb_mux_tree_pipe.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_tree_pipe_pkg.sv
// Shared sizing and slicing helpers for the mux tree family.
package mux_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r = r + 1;
    return r;
  endfunction

  // LSB position of channel/node ch in a flat vector of width-bit slots.
  function automatic int unsigned chan_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

  // First node index of tree level k when leaves are nodes 0..n_in-1.
  function automatic int unsigned level_base(input int unsigned n_in, input int unsigned k);
    return 2 * n_in - 2 * (n_in >> k);
  endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Channel bus of the pipelined mux tree: parallel sources in, tagged sample out.
interface mux_tree_pipe_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4
);
  localparam int SW = int'(clog2(N_IN));

  logic [N_IN*WIDTH-1:0] in_data;
  logic                  in_valid;
  logic [SW-1:0]         sel;
  logic                  mode;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic [SW-1:0]         out_sel;

  modport master (
    output in_data, in_valid, sel, mode,
    input  out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, sel, mode,
    output out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_tree_pipe_mux2_stage.sv
// One 2:1 lane of the tree with its data/valid/tag register (bypassed when PIPE=0).
module mux2_stage #(
  parameter int WIDTH = 8,
  parameter int SW    = 2,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_a,
  input  logic [WIDTH-1:0] d_b,
  input  logic             pick,
  input  logic             valid,
  input  logic [SW-1:0]    tag,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [SW-1:0]    y_tag
);
  logic [WIDTH-1:0] mux;

  always_comb mux = pick ? d_b : d_a;

  generate
    if (PIPE != 0) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          y       <= '0;
          y_valid <= 1'b0;
          y_tag   <= '0;
        end else begin
          y_valid <= valid;
          if (valid) begin
            y     <= mux;
            y_tag <= tag;
          end
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      always_comb unused_clk_rst = clk | rst;
      always_comb begin
        y       = mux;
        y_valid = valid;
        y_tag   = tag;
      end
    end
  endgenerate
endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree with valid/channel-tag sideband and round-robin auto-scan.
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int PIPE  = 1
) (
  input logic            clk,
  input logic            rst,
  mux_tree_pipe_if.slave bus
);
  localparam int SW     = int'(clog2(N_IN));
  localparam int LEVELS = SW;
  localparam int NODES  = 2 * N_IN - 1;

  logic [SW-1:0]             scan_cnt;
  logic [SW-1:0]             eff_sel;
  logic [NODES*WIDTH-1:0]    tree_data;
  logic [N_IN-2:0]           node_valid;
  logic [(N_IN-1)*SW-1:0]    node_tag;
  logic [LEVELS:0]           lvl_valid;
  logic [(LEVELS+1)*SW-1:0]  lvl_tag;

  always_comb eff_sel = bus.mode ? scan_cnt : bus.sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                scan_cnt <= '0;
    else if (!bus.mode)     scan_cnt <= '0;
    else if (bus.in_valid)  scan_cnt <= scan_cnt + 1'b1;
  end

  assign tree_data[N_IN*WIDTH-1:0] = bus.in_data;
  assign lvl_valid[0]              = bus.in_valid;
  assign lvl_tag[SW-1:0]           = eff_sel;

  // The last level stays combinational: the top-level output register closes
  // the pipe, giving LEVELS cycles with PIPE=1 and a single cycle with PIPE=0.
  generate
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
      localparam int LANES = N_IN >> (k + 1);
      localparam int SRC   = int'(level_base(N_IN, k));
      localparam int DST   = int'(level_base(N_IN, k + 1));
      logic          valid_any;
      logic [SW-1:0] tag_any;

      for (genvar j = 0; j < LANES; j++) begin : g_lane
        mux2_stage #(
          .WIDTH (WIDTH),
          .SW    (SW),
          .PIPE  ((PIPE != 0 && k < LEVELS - 1) ? 1 : 0)
        ) u_stage (
          .clk     (clk),
          .rst     (rst),
          .d_a     (tree_data[chan_lo(SRC + 2*j, WIDTH) +: WIDTH]),
          .d_b     (tree_data[chan_lo(SRC + 2*j + 1, WIDTH) +: WIDTH]),
          .pick    (lvl_tag[k*SW + k]),
          .valid   (lvl_valid[k]),
          .tag     (lvl_tag[k*SW +: SW]),
          .y       (tree_data[chan_lo(DST + j, WIDTH) +: WIDTH]),
          .y_valid (node_valid[DST + j - N_IN]),
          .y_tag   (node_tag[(DST + j - N_IN)*SW +: SW])
        );
      end

      // Every lane carries an identical sideband copy; merging them keeps all copies live.
      always_comb begin
        valid_any = 1'b0;
        tag_any   = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
          valid_any = valid_any | node_valid[DST + j - N_IN +: 1];
          tag_any   = tag_any | node_tag[(DST + j - N_IN)*SW +: SW];
        end
      end

      assign lvl_valid[k+1]           = valid_any;
      assign lvl_tag[(k+1)*SW +: SW]  = tag_any;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sel   <= '0;
    end else begin
      bus.out_valid <= lvl_valid[LEVELS];
      if (lvl_valid[LEVELS]) begin
        bus.out_data <= tree_data[chan_lo(NODES - 1, WIDTH) +: WIDTH];
        bus.out_sel  <= lvl_tag[LEVELS*SW +: SW];
      end
    end
  end
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench: three mux tree configurations against a delay-line channel model.
module tb_mux_tree_pipe;
  logic clk;
  logic rst;

  mux_tree_pipe_if #(.WIDTH(8), .N_IN(4)) i4 ();
  mux_tree_pipe_if #(.WIDTH(8), .N_IN(8)) i8 ();
  mux_tree_pipe_if #(.WIDTH(8), .N_IN(8)) ic ();

  mux_tree_pipe #(.WIDTH(8), .N_IN(4), .PIPE(1)) u_n4p (.clk(clk), .rst(rst), .bus(i4));
  mux_tree_pipe #(.WIDTH(8), .N_IN(8), .PIPE(1)) u_n8p (.clk(clk), .rst(rst), .bus(i8));
  mux_tree_pipe #(.WIDTH(8), .N_IN(8), .PIPE(0)) u_n8c (.clk(clk), .rst(rst), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model configuration: latency in cycles and channel count per instance.
  localparam int LAT [3] = '{2, 3, 1};
  localparam int NIN [3] = '{4, 8, 8};
  string nm [3] = '{"n4p", "n8p", "n8c"};

  logic [63:0] m_din [3];
  int m_valid [3], m_mode [3], m_sel [3];
  int a_v [3], a_d [3], a_s [3];

  always_comb begin
    m_din[0] = 64'(i4.in_data);  m_din[1] = i8.in_data;       m_din[2] = ic.in_data;
    m_valid[0] = int'(i4.in_valid); m_valid[1] = int'(i8.in_valid); m_valid[2] = int'(ic.in_valid);
    m_mode[0] = int'(i4.mode);   m_mode[1] = int'(i8.mode);   m_mode[2] = int'(ic.mode);
    m_sel[0] = int'(i4.sel);     m_sel[1] = int'(i8.sel);     m_sel[2] = int'(ic.sel);
    a_v[0] = int'(i4.out_valid); a_v[1] = int'(i8.out_valid); a_v[2] = int'(ic.out_valid);
    a_d[0] = int'(i4.out_data);  a_d[1] = int'(i8.out_data);  a_d[2] = int'(ic.out_data);
    a_s[0] = int'(i4.out_sel);   a_s[1] = int'(i8.out_sel);   a_s[2] = int'(ic.out_sel);
  end

  // Delay line of launched samples, index 0 = launched at the latest edge.
  bit       pv [3][8];
  bit [7:0] pd [3][8];
  int       ps [3][8];
  int       sc [3];

  function automatic int ch_of(input int d);
    return (m_mode[d] != 0) ? sc[d] : m_sel[d];
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) begin
      sc[d] = 0;
      for (int i = 0; i < 8; i++) begin pv[d][i] = 0; pd[d][i] = 0; ps[d][i] = 0; end
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          sc[d] = 0;
          for (int i = 0; i < 8; i++) begin pv[d][i] = 0; pd[d][i] = 0; ps[d][i] = 0; end
        end else begin
          int ch;
          ch = ch_of(d);
          for (int i = 7; i > 0; i--) begin
            pv[d][i] = pv[d][i-1]; pd[d][i] = pd[d][i-1]; ps[d][i] = ps[d][i-1];
          end
          pv[d][0] = (m_valid[d] != 0);
          pd[d][0] = m_din[d][ch*8 +: 8];
          ps[d][0] = ch;
          if (m_mode[d] == 0)       sc[d] = 0;
          else if (m_valid[d] != 0) sc[d] = (sc[d] + 1) % NIN[d];
        end
      end
    end
  end

  // Every cycle: outputs equal the sample launched LAT cycles earlier, or hold the last one.
  int hd [3], hs [3];
  initial begin
    for (int d = 0; d < 3; d++) begin hd[d] = 0; hs[d] = 0; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          hd[d] = 0; hs[d] = 0;
        end else begin
          int v;
          v = int'(pv[d][LAT[d]-1]);
          if (v != 0) begin hd[d] = int'(pd[d][LAT[d]-1]); hs[d] = ps[d][LAT[d]-1]; end
          chk({nm[d], ".model.valid"}, a_v[d], v);
          chk({nm[d], ".model.data"},  a_d[d], hd[d]);
          chk({nm[d], ".model.sel"},   a_s[d], hs[d]);
        end
      end
    end
  end

  int pat_v [7] = '{1, 1, 0, 1, 1, 1, 1};
  int pat_s [7] = '{0, 1, 0, 2, 3, 0, 1};
  int pat_d [7] = '{'h11, 'h22, 0, 'h33, 'h44, 'h11, 'h22};

  initial begin
    rst = 1'b1;
    i4.in_data = '0; i4.in_valid = 1'b0; i4.sel = '0; i4.mode = 1'b0;
    i8.in_data = '0; i8.in_valid = 1'b0; i8.sel = '0; i8.mode = 1'b0;
    ic.in_data = '0; ic.in_valid = 1'b0; ic.sel = '0; ic.mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.valid", int'(i4.out_valid), 0);
    chk("reset.data",  int'(i4.out_data), 0);
    chk("reset.sel",   int'(i8.out_sel), 0);
    rst = 1'b0;

    // Fixed select, 4 channels, two-cycle latency, single-cycle output.
    i4.in_data = 32'h44332211; i4.sel = 2'd2; i4.in_valid = 1'b1;
    @(negedge clk);
    i4.in_valid = 1'b0;
    chk("fixed.early_valid", int'(i4.out_valid), 0);
    @(negedge clk);
    chk("fixed.valid", int'(i4.out_valid), 1);
    chk("fixed.data",  int'(i4.out_data), 'h33);
    chk("fixed.sel",   int'(i4.out_sel), 2);
    @(negedge clk);
    chk("fixed.once", int'(i4.out_valid), 0);

    // Back-to-back streaming on 8 channels.
    for (int k = 0; k < 8; k++) i8.in_data[k*8 +: 8] = 8'(8'hA0 + k);
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin i8.sel = 3'(i); i8.in_valid = 1'b1; end
      else i8.in_valid = 1'b0;
      @(negedge clk);
      if (i >= 2 && i < 10) begin
        chk("stream.valid", int'(i8.out_valid), 1);
        chk("stream.data",  int'(i8.out_data), 'hA0 + i - 2);
        chk("stream.sel",   int'(i8.out_sel), i - 2);
      end else begin
        chk("stream.idle", int'(i8.out_valid), 0);
      end
    end

    // Auto-scan with a gap after the second sample and a wrap.
    i4.mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      i4.in_valid = (i < 7) ? (pat_v[i] != 0) : 1'b0;
      @(negedge clk);
      if (i >= 1) begin
        if (i - 1 < 7) begin
          chk("scan.valid", int'(i4.out_valid), pat_v[i-1]);
          if (pat_v[i-1] != 0) begin
            chk("scan.sel",  int'(i4.out_sel), pat_s[i-1]);
            chk("scan.data", int'(i4.out_data), pat_d[i-1]);
          end
        end else begin
          chk("scan.tail", int'(i4.out_valid), 0);
        end
      end
    end
    i4.mode = 1'b0; i4.in_valid = 1'b0;
    @(negedge clk);

    // Combinational tree, single output register.
    for (int k = 0; k < 8; k++) ic.in_data[k*8 +: 8] = 8'(8'hC0 + k);
    ic.sel = 3'd5; ic.in_valid = 1'b1;
    @(negedge clk);
    ic.in_valid = 1'b0;
    chk("comb.valid", int'(ic.out_valid), 1);
    chk("comb.data",  int'(ic.out_data), 'hC5);
    chk("comb.sel",   int'(ic.out_sel), 5);
    @(negedge clk);
    chk("comb.once", int'(ic.out_valid), 0);

    // Mode switch with scan samples in flight.
    i4.mode = 1'b1; i4.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("switch.tag0", int'(i4.out_sel), 0);
    chk("switch.data0", int'(i4.out_data), 'h11);
    i4.mode = 1'b0; i4.sel = 2'd3;
    @(negedge clk);
    i4.in_valid = 1'b0;
    chk("switch.tag1", int'(i4.out_sel), 1);
    chk("switch.data1", int'(i4.out_data), 'h22);
    @(negedge clk);
    chk("switch.ext_valid", int'(i4.out_valid), 1);
    chk("switch.ext_sel", int'(i4.out_sel), 3);
    chk("switch.ext_data", int'(i4.out_data), 'h44);
    @(negedge clk);
    chk("switch.end", int'(i4.out_valid), 0);

    // Asynchronous reset in the middle of a scan stream.
    i4.mode = 1'b1; i4.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.pre_valid", int'(i4.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst.now_valid", int'(i4.out_valid), 0);
    chk("rst.now_data",  int'(i4.out_data), 0);
    chk("rst.now_sel",   int'(i4.out_sel), 0);
    chk("rst.now_n8p",   int'(i8.out_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; i4.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst.no_stale", int'(i4.out_valid), 0);
    end
    i4.in_valid = 1'b1;
    @(negedge clk);
    i4.in_valid = 1'b0;
    @(negedge clk);
    chk("rst.restart_valid", int'(i4.out_valid), 1);
    chk("rst.restart_sel",   int'(i4.out_sel), 0);
    chk("rst.restart_data",  int'(i4.out_data), 'h11);
    i4.mode = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
